ascii_tile_mapper: RTL and testbench
====================================

Name: ascii_tile_mapper

Overview:
- Downstream consumer of the camera decoder's frame buffer.
- Once per frame, on a start pulse, reads the 4-bit-per-pixel BRAM frame (640x480, linear addressing) tile by tile.
- Averages each TILE_W x TILE_H tile and maps the mean brightness to an ASCII code.
- Writes one character per tile into the character buffer consumed by the text/VGA renderer.

Parameters:
- COLS, 640, frame width in pixels.
- ROWS, 480, frame height in pixels.
- TILE_W, 8, tile width in pixels; power of two; divides COLS.
- TILE_H, 16, tile height in pixels; power of two; divides ROWS.

Ports:
- PCLK  input  1  single clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse, frame buffer complete; ignored unless IDLE.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last character write.
- fb_addr  output  32  frame buffer read address, matching the decoder's write address (row*COLS+col).
- fb_en  output  1  frame buffer read enable.
- fb_dout  input  4  BRAM read data; valid exactly 1 cycle after fb_en.
- char_addr  output  12  character buffer address, tile_row*(COLS/TILE_W)+tile_col.
- char_data  output  8  ASCII code.
- char_we  output  1  character buffer write strobe.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; busy=0, done=0, fb_en=0, fb_addr=0, char_we=0, char_addr=0, char_data=0; accumulator and all counters 0.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: start=1 -> FETCH, with tile_row=0, tile_col=0, px=0, py=0, acc=0.
- FETCH: fb_en=1 each cycle.
  - fb_addr = (tile_row*TILE_H+py)*COLS + tile_col*TILE_W + px.
  - px increments; on wrap px=0 and py increments.
  - After TILE_W*TILE_H issues (128 by default) -> DRAIN.
- Read valid: a 1-cycle delayed copy of fb_en. Whenever the delayed valid is high, acc += fb_dout.
- Accumulator width: clog2(TILE_W*TILE_H*15+1) bits (11 by default); never saturates.
- DRAIN: fb_en=0; the last pixel is accumulated -> WRITE.
- WRITE (1 cycle): char_we=1; char_data = RAMP[acc >> log2(TILE_W*TILE_H)]. The mean is 4 bits, truncated, not rounded.
- WRITE exit:
  - acc cleared.
  - If tile is last (tile_row=ROWS/TILE_H-1 and tile_col=COLS/TILE_W-1) -> DONE.
  - Else tile_col increments (wraps to 0 with tile_row+1), char_addr increments, -> FETCH.
- DONE: done=1 for one cycle; busy=0 next cycle -> IDLE.
- RAMP, index 0..15: ' ' '.' ',' ':' ';' '-' '~' '=' '+' '*' 'c' 'o' 'O' '#' '%' '@'. Index 0 is darkest, 15 brightest.
- Timing:
  - Tile cost: TILE_W*TILE_H+2 cycles (130 by default).
  - Frame cost: 2400 tiles * 130 = 312000 cycles from the first FETCH to the WRITE of the last tile; done follows one cycle later.
- char_we and fb_en are never high in the same cycle. char_addr holds its last value between writes.
- start while busy: ignored, no restart, no effect on counters.
- Reset mid-frame: immediate abort. No done pulse, no partial write completes. A fresh start reprocesses from tile 0.
- start and done in the same cycle: start is ignored, because the FSM is not yet IDLE.

Decomposition:
- Shared package ascii_pkg holds:
  - COLS, ROWS, TILE_W, TILE_H defaults.
  - Derived TILES_X=80, TILES_Y=30, TILE_PIX=128.
  - FSM state enum.
  - 16-entry RAMP constant array of byte.
- One sub-module, ascii_ramp_lut: combinational 4-bit level -> 8-bit ASCII, registered in WRITE by the parent.
- Address generation and the accumulator stay in the parent.

Test Plan:
- BRAM model all 0, start pulse -> 2400 writes, all char_data=0x20. done pulses once, 312001 cycles after the first FETCH cycle.
- BRAM model all 4'hF -> every char_data=0x40 ('@'); char_addr sequence 0..2399, strictly increasing.
- Tile (0,0) with 127 pixels=15 and 1 pixel=0 -> acc=1905, mean 14, char_addr 0 gets 0x25 ('%'). Checkerboard 0/15 tile -> mean 7, 0x3D ('=').
- Address walk:
  - Tile 1 first fb_addr=8.
  - Tile 0 second row fb_addr=640.
  - Tile 80 (row 1, col 0) first fb_addr=10240, char_addr=80.
  - Last issued fb_addr=307199.
- start pulsed at cycles 5 and 1000 while busy -> single frame pass; exactly one done; no write to char_addr 0 after the first.
- reset_n low mid-FETCH of tile 37 -> all outputs 0 asynchronously; no done. A later start reprocesses from char_addr 0 and completes normally.

Source files
------------

// File: rtl/ascii_pkg.sv
// Shared constants, FSM state type and brightness ramp for the ASCII tile mapper.
package ascii_pkg;

   localparam int COLS_DEF   = 640;
   localparam int ROWS_DEF   = 480;
   localparam int TILE_W_DEF = 8;
   localparam int TILE_H_DEF = 16;

   localparam int TILES_X  = COLS_DEF / TILE_W_DEF;
   localparam int TILES_Y  = ROWS_DEF / TILE_H_DEF;
   localparam int TILE_PIX = TILE_W_DEF * TILE_H_DEF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   // Darkest (index 0) to brightest (index 15): " .,:;-~=+*coO#%@"
   localparam byte RAMP [16] = '{
      8'h20, 8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h2D, 8'h7E, 8'h3D,
      8'h2B, 8'h2A, 8'h63, 8'h6F, 8'h4F, 8'h23, 8'h25, 8'h40
   };

endpackage

// File: rtl/ascii_ramp_lut.sv
// Combinational map from a 4-bit mean brightness level to its ASCII glyph.
module ascii_ramp_lut
   import ascii_pkg::*;
(
   input  logic [3:0] level,
   output logic [7:0] ascii
);

   assign ascii = RAMP[level];

endmodule

// File: rtl/ascii_tile_mapper.sv
// Walks the 4bpp frame buffer tile by tile, averages each tile and writes one
// ASCII character per tile into the character buffer.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one pixel read per cycle for the current tile
// DRAIN | no read issued; last pixel of the tile is accumulated
// WRITE | character write strobe for the finished tile
// DONE  | one-cycle done pulse, back to IDLE
module ascii_tile_mapper
   import ascii_pkg::*;
#(
   parameter int COLS   = COLS_DEF,
   parameter int ROWS   = ROWS_DEF,
   parameter int TILE_W = TILE_W_DEF,
   parameter int TILE_H = TILE_H_DEF
) (
   input  logic        PCLK,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] fb_addr,
   output logic        fb_en,
   input  logic [3:0]  fb_dout,
   output logic [11:0] char_addr,
   output logic [7:0]  char_data,
   output logic        char_we
);

   localparam int TX      = COLS / TILE_W;
   localparam int TY      = ROWS / TILE_H;
   localparam int TP      = TILE_W * TILE_H;
   localparam int AW      = $clog2(TP * 15 + 1);
   localparam int TP_LOG2 = $clog2(TP);
   localparam int PXW     = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int PYW     = (TILE_H > 1) ? $clog2(TILE_H) : 1;

   logic [1:0]     r_rst_sync;
   logic           w_rst_n;
   state_t         r_state;
   logic [PXW-1:0] r_px, w_px_n;
   logic [PYW-1:0] r_py, w_py_n;
   logic [11:0]    r_tile_row, r_tile_col, w_trow_n, w_tcol_n;
   logic [AW-1:0]  r_acc, w_acc_sum;
   logic           r_vld;
   logic           r_busy, r_done, r_fb_en, r_char_we;
   logic [31:0]    r_fb_addr, w_addr_n;
   logic [11:0]    r_char_addr;
   logic [7:0]     r_char_data, w_ascii;
   logic           w_px_last, w_py_last, w_tile_last;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge PCLK or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= '0;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_px_last   = (r_px == PXW'(TILE_W - 1));
   assign w_py_last   = (r_py == PYW'(TILE_H - 1));
   assign w_tile_last = (r_tile_row == 12'(TY - 1)) && (r_tile_col == 12'(TX - 1));
   assign w_acc_sum   = r_acc + (r_vld ? AW'(fb_dout) : AW'(0));

   // Counter values for the next issued pixel; outside FETCH/WRITE this is the frame origin.
   always_comb begin
      w_px_n   = '0;
      w_py_n   = '0;
      w_trow_n = '0;
      w_tcol_n = '0;
      case (r_state)
         S_FETCH: begin
            w_trow_n = r_tile_row;
            w_tcol_n = r_tile_col;
            w_py_n   = r_py;
            if (w_px_last) begin
               w_py_n = r_py + 1'b1;
            end else begin
               w_px_n = r_px + 1'b1;
            end
         end
         S_WRITE: begin
            if (r_tile_col == 12'(TX - 1)) begin
               w_trow_n = r_tile_row + 12'd1;
            end else begin
               w_trow_n = r_tile_row;
               w_tcol_n = r_tile_col + 12'd1;
            end
         end
         default: ;
      endcase
      w_addr_n = (32'(w_trow_n) * TILE_H + 32'(w_py_n)) * COLS
               + 32'(w_tcol_n) * TILE_W + 32'(w_px_n);
   end

   ascii_ramp_lut u_ramp (
      .level (w_acc_sum[TP_LOG2 +: 4]),
      .ascii (w_ascii)
   );

   always_ff @(posedge PCLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= S_IDLE;
         r_px        <= '0;
         r_py        <= '0;
         r_tile_row  <= '0;
         r_tile_col  <= '0;
         r_acc       <= '0;
         r_vld       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fb_en     <= 1'b0;
         r_fb_addr   <= '0;
         r_char_we   <= 1'b0;
         r_char_addr <= '0;
         r_char_data <= '0;
      end else begin
         r_vld <= r_fb_en;
         if (r_vld) r_acc <= w_acc_sum;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_FETCH;
                  r_busy      <= 1'b1;
                  r_fb_en     <= 1'b1;
                  r_fb_addr   <= w_addr_n;
                  r_px        <= w_px_n;
                  r_py        <= w_py_n;
                  r_tile_row  <= w_trow_n;
                  r_tile_col  <= w_tcol_n;
                  r_acc       <= '0;
                  r_char_addr <= '0;
               end
            end
            S_FETCH: begin
               if (w_px_last && w_py_last) begin
                  r_state <= S_DRAIN;
                  r_fb_en <= 1'b0;
               end else begin
                  r_px      <= w_px_n;
                  r_py      <= w_py_n;
                  r_fb_addr <= w_addr_n;
               end
            end
            S_DRAIN: begin
               r_state     <= S_WRITE;
               r_char_we   <= 1'b1;
               r_char_data <= w_ascii;
            end
            S_WRITE: begin
               r_char_we <= 1'b0;
               r_acc     <= '0;
               if (w_tile_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state     <= S_FETCH;
                  r_fb_en     <= 1'b1;
                  r_fb_addr   <= w_addr_n;
                  r_px        <= w_px_n;
                  r_py        <= w_py_n;
                  r_tile_row  <= w_trow_n;
                  r_tile_col  <= w_tcol_n;
                  r_char_addr <= r_char_addr + 12'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign fb_en     = r_fb_en;
   assign fb_addr   = r_fb_addr;
   assign char_we   = r_char_we;
   assign char_addr = r_char_addr;
   assign char_data = r_char_data;

endmodule

// File: tb/tb_ascii_tile_mapper.sv
// Directed bench for ascii_tile_mapper on a 640x32 frame (80x2 tiles of 8x16).
module tb_ascii_tile_mapper;

   localparam int NT        = 160;
   localparam int FRAME_CYC = NT * 130;

   logic        PCLK = 1'b0;
   logic        reset_n;
   logic        start;
   logic        busy, done, fb_en, char_we;
   logic [31:0] fb_addr;
   logic [3:0]  fb_dout;
   logic [11:0] char_addr;
   logic [7:0]  char_data;

   int n_pass  = 0;
   int n_total = 0;
   int mode    = 0;

   ascii_tile_mapper #(.COLS(640), .ROWS(32), .TILE_W(8), .TILE_H(16)) dut (
      .PCLK      (PCLK),
      .reset_n   (reset_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .fb_addr   (fb_addr),
      .fb_en     (fb_en),
      .fb_dout   (fb_dout),
      .char_addr (char_addr),
      .char_data (char_data),
      .char_we   (char_we)
   );

   always #5 PCLK = ~PCLK;

   // Mode 1: tile0 = all 15 but one 0, tile1 = checkerboard, tile2 = all 0, others all 15.
   function automatic logic [3:0] pix(input logic [31:0] a);
      int ai, row, col, tr, tc, px, py;
      ai = int'(a);
      row = ai / 640; col = ai % 640;
      tr = row / 16;  tc = col / 8;
      py = row % 16;  px = col % 8;
      if (mode == 0) return 4'h0;
      if (tr == 0 && tc == 0) return (px == 3 && py == 5) ? 4'h0 : 4'hF;
      if (tr == 0 && tc == 1) return ((px + py) % 2 == 1) ? 4'hF : 4'h0;
      if (tr == 0 && tc == 2) return 4'h0;
      return 4'hF;
   endfunction

   always @(posedge PCLK) if (fb_en) fb_dout <= pix(fb_addr);

   int cyc = 0, first_fetch, done_cyc, done_cnt, we_cnt, overlap, order_err;
   int issue_idx, last_fb_addr, t0_row1_addr, prev_caddr;
   logic prev_fb_en;
   logic [7:0] got_char [NT];
   int write_hits [NT];
   int wr_addr_seq [NT];
   int tile_first_addr [NT];

   task automatic clear_log();
      first_fetch = -1; done_cyc = -1; done_cnt = 0; we_cnt = 0; overlap = 0;
      order_err = 0; issue_idx = 0; last_fb_addr = -1; t0_row1_addr = -1;
      prev_caddr = -1; prev_fb_en = 1'b0;
      for (int i = 0; i < NT; i++) begin
         got_char[i] = 8'h00; write_hits[i] = 0; wr_addr_seq[i] = -1; tile_first_addr[i] = -1;
      end
   endtask

   always @(negedge PCLK) begin
      cyc++;
      if (fb_en) begin
         if (first_fetch < 0) first_fetch = cyc;
         if (!prev_fb_en) begin
            if (we_cnt < NT) tile_first_addr[we_cnt] = int'(fb_addr);
            issue_idx = 0;
         end
         if (we_cnt == 0 && issue_idx == 8) t0_row1_addr = int'(fb_addr);
         issue_idx++;
         last_fb_addr = int'(fb_addr);
      end
      prev_fb_en = fb_en;
      if (fb_en && char_we) overlap++;
      if (char_we) begin
         if (int'(char_addr) < NT) begin
            got_char[char_addr] = char_data;
            write_hits[char_addr]++;
         end
         if (we_cnt < NT) wr_addr_seq[we_cnt] = int'(char_addr);
         if (int'(char_addr) != prev_caddr + 1) order_err++;
         prev_caddr = int'(char_addr);
         we_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic pulse_start();
      @(negedge PCLK); start = 1'b1;
      @(negedge PCLK); start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge PCLK);
         if (done_cnt > 0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0;
      repeat (3) @(negedge PCLK);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
      n_total++; if (fb_en !== 1'b0) $display("FAIL reset_fb_en got=%0b exp=0", fb_en); else n_pass++;
      n_total++; if (fb_addr !== 32'd0) $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); else n_pass++;
      n_total++; if (char_we !== 1'b0) $display("FAIL reset_char_we got=%0b exp=0", char_we); else n_pass++;
      n_total++; if (char_addr !== 12'd0) $display("FAIL reset_char_addr got=%0d exp=0", char_addr); else n_pass++;
      n_total++; if (char_data !== 8'd0) $display("FAIL reset_char_data got=%0h exp=0", char_data); else n_pass++;
      reset_n = 1'b1;
      repeat (5) @(negedge PCLK);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_busy got=%0b exp=0", busy); else n_pass++;
   endtask

   task automatic test_pattern_frame();
      bit ok;
      int bad, start_cyc;
      mode = 1;
      clear_log();
      pulse_start();
      start_cyc = cyc;
      n_total++; if (busy !== 1'b1 || fb_en !== 1'b1) $display("FAIL start_busy got=%0b/%0b exp=1/1", busy, fb_en); else n_pass++;
      repeat (3) @(negedge PCLK);
      pulse_start();
      while (cyc < start_cyc + 995) @(negedge PCLK);
      pulse_start();
      wait_done(FRAME_CYC + 500, ok);
      repeat (20) @(negedge PCLK);
      n_total++; if (ok !== 1'b1) $display("FAIL frame1_timeout got=%0b exp=1", ok); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL frame1_done_count got=%0d exp=1", done_cnt); else n_pass++;
      n_total++; if (done_cyc - first_fetch + 1 != FRAME_CYC + 1)
         $display("FAIL frame1_done_timing got=%0d exp=%0d", done_cyc - first_fetch + 1, FRAME_CYC + 1); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL frame1_busy_after got=%0b exp=0", busy); else n_pass++;
      n_total++; if (we_cnt != NT) $display("FAIL frame1_writes got=%0d exp=%0d", we_cnt, NT); else n_pass++;
      n_total++; if (order_err != 0) $display("FAIL frame1_char_addr_order got=%0d exp=0", order_err); else n_pass++;
      n_total++; if (overlap != 0) $display("FAIL frame1_we_en_overlap got=%0d exp=0", overlap); else n_pass++;
      n_total++; if (write_hits[0] != 1) $display("FAIL frame1_addr0_hits got=%0d exp=1", write_hits[0]); else n_pass++;
      n_total++; if (got_char[0] !== 8'h25) $display("FAIL tile0_mean14 got=%0h exp=25", got_char[0]); else n_pass++;
      n_total++; if (got_char[1] !== 8'h3D) $display("FAIL tile1_checker got=%0h exp=3d", got_char[1]); else n_pass++;
      n_total++; if (got_char[2] !== 8'h20) $display("FAIL tile2_dark got=%0h exp=20", got_char[2]); else n_pass++;
      bad = 0;
      for (int i = 3; i < NT; i++) if (got_char[i] !== 8'h40 || write_hits[i] != 1) bad++;
      n_total++; if (bad != 0) $display("FAIL bright_tiles got=%0d bad exp=0", bad); else n_pass++;
      n_total++; if (tile_first_addr[1] != 8) $display("FAIL tile1_first_addr got=%0d exp=8", tile_first_addr[1]); else n_pass++;
      n_total++; if (t0_row1_addr != 640) $display("FAIL tile0_row1_addr got=%0d exp=640", t0_row1_addr); else n_pass++;
      n_total++; if (tile_first_addr[80] != 10240) $display("FAIL tile80_first_addr got=%0d exp=10240", tile_first_addr[80]); else n_pass++;
      n_total++; if (wr_addr_seq[80] != 80) $display("FAIL tile80_char_addr got=%0d exp=80", wr_addr_seq[80]); else n_pass++;
      n_total++; if (last_fb_addr != 20479) $display("FAIL last_fb_addr got=%0d exp=20479", last_fb_addr); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok, hit;
      int bad;
      mode = 0;
      clear_log();
      pulse_start();
      hit = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge PCLK);
         if (we_cnt == 37 && fb_en && issue_idx >= 20) begin hit = 1'b1; break; end
      end
      n_total++; if (hit !== 1'b1) $display("FAIL reach_tile37 got=%0b exp=1", hit); else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++; if ({busy, done, fb_en, char_we} !== 4'b0)
         $display("FAIL abort_flags got=%0b exp=0000", {busy, done, fb_en, char_we}); else n_pass++;
      n_total++; if (fb_addr !== 32'd0 || char_addr !== 12'd0 || char_data !== 8'd0)
         $display("FAIL abort_buses got=%0d/%0d/%0h exp=0/0/0", fb_addr, char_addr, char_data); else n_pass++;
      repeat (5) @(negedge PCLK);
      reset_n = 1'b1;
      repeat (10) @(negedge PCLK);
      n_total++; if (done_cnt != 0) $display("FAIL abort_no_done got=%0d exp=0", done_cnt); else n_pass++;
      clear_log();
      pulse_start();
      wait_done(FRAME_CYC + 500, ok);
      repeat (5) @(negedge PCLK);
      n_total++; if (ok !== 1'b1) $display("FAIL frame2_timeout got=%0b exp=1", ok); else n_pass++;
      n_total++; if (done_cnt != 1) $display("FAIL frame2_done_count got=%0d exp=1", done_cnt); else n_pass++;
      n_total++; if (we_cnt != NT) $display("FAIL frame2_writes got=%0d exp=%0d", we_cnt, NT); else n_pass++;
      n_total++; if (wr_addr_seq[0] != 0 || order_err != 0)
         $display("FAIL frame2_restart_order got=%0d/%0d exp=0/0", wr_addr_seq[0], order_err); else n_pass++;
      n_total++; if (tile_first_addr[0] != 0) $display("FAIL frame2_first_addr got=%0d exp=0", tile_first_addr[0]); else n_pass++;
      bad = 0;
      for (int i = 0; i < NT; i++) if (got_char[i] !== 8'h20 || write_hits[i] != 1) bad++;
      n_total++; if (bad != 0) $display("FAIL dark_frame got=%0d bad exp=0", bad); else n_pass++;
   endtask

   initial begin
      clear_log();
      test_reset();
      test_pattern_frame();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
